// File: rtl/ea_unit.sv
// ea_unit: effective-address stage (page-zero/current-page/indirect/auto-index); auto-index built only with EA_AUTOINDEX_EN
module ea_unit
`ifdef EA_AUTOINDEX_EN
  #(parameter logic [11:0] AI_BASE = 12'o0010)
`endif
  (
  input  logic        CLK,
  input  logic        CLR_N,
  input  logic        START,
  input  logic [11:0] IR,
  input  logic [11:0] PC,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [11:0] MEM_ADDR,
  output logic [11:0] MEM_WDATA,
  input  logic [11:0] MEM_RDATA,
  input  logic        MEM_ACK,
  output logic [11:0] EA,
  output logic        BUSY,
  output logic        DONE
);
`ifdef EA_AUTOINDEX_EN
  typedef enum logic [1:0] {IDLE, IND_RD, AI_WR, FIN} state_t;
`else
  typedef enum logic [1:0] {IDLE, IND_RD, FIN} state_t;
`endif
  state_t state, state_nx;
  logic [11:0] da;
  assign da = IR[7] ? {PC[11:7], IR[6:0]} : {5'b0, IR[6:0]};
`ifdef EA_AUTOINDEX_EN
  logic ai_hit;
  assign ai_hit = MEM_ADDR[11:3] == AI_BASE[11:3];
`else
  assign MEM_WE = 1'b0;
  assign MEM_WDATA = 12'o0;
`endif
  // state register
  always_ff @(posedge CLK or negedge CLR_N)
    if (!CLR_N) state <= IDLE;
    else state <= state_nx;
  // next state; BUSY/DONE decoded from the current state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (START) state_nx = IR[8] ? IND_RD : FIN;
`ifdef EA_AUTOINDEX_EN
      IND_RD: if (MEM_ACK) state_nx = ai_hit ? AI_WR : FIN;
      AI_WR: if (MEM_REQ && MEM_ACK) state_nx = FIN;
`else
      IND_RD: if (MEM_ACK) state_nx = FIN;
`endif
      FIN: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    BUSY = state != IDLE;
    DONE = state == FIN;
  end
  // memory port and EA; MEM_ADDR keeps DA from the read through the write-back
  always_ff @(posedge CLK or negedge CLR_N)
    if (!CLR_N) begin
      EA <= 12'o0;
      MEM_REQ <= 1'b0;
      MEM_ADDR <= 12'o0;
`ifdef EA_AUTOINDEX_EN
      MEM_WE <= 1'b0;
      MEM_WDATA <= 12'o0;
`endif
    end else begin
      case (state)
        IDLE:
          if (START) begin
            if (IR[8]) begin
              MEM_REQ <= 1'b1;
              MEM_ADDR <= da;
            end else EA <= da;
          end
        IND_RD:
          if (MEM_ACK) begin
            MEM_REQ <= 1'b0;
`ifdef EA_AUTOINDEX_EN
            EA <= ai_hit ? MEM_RDATA + 12'd1 : MEM_RDATA;
            MEM_WDATA <= MEM_RDATA + 12'd1;
`else
            EA <= MEM_RDATA;
`endif
          end
`ifdef EA_AUTOINDEX_EN
        AI_WR:
          if (!MEM_REQ) begin
            MEM_REQ <= 1'b1;
            MEM_WE <= 1'b1;
          end else if (MEM_ACK) begin
            MEM_REQ <= 1'b0;
            MEM_WE <= 1'b0;
          end
`endif
        default: ;
      endcase
    end
endmodule

// File: tb/tb_ea_unit.sv
// tb_ea_unit: vector table, hand sequences and random checks of ea_unit against a memory responder and reference model
module tb_ea_unit;
  logic CLK = 0, CLR_N = 0, START = 0, MEM_ACK = 0;
  logic [11:0] IR = 0, PC = 0, MEM_RDATA = 0;
  logic MEM_REQ, MEM_WE, BUSY, DONE;
  logic [11:0] MEM_ADDR, MEM_WDATA, EA;
`ifdef EA_AUTOINDEX_EN
  localparam bit EN = 1;
`else
  localparam bit EN = 0;
`endif

  ea_unit dut (.CLK(CLK), .CLR_N(CLR_N), .START(START), .IR(IR), .PC(PC),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK), .EA(EA), .BUSY(BUSY), .DONE(DONE));

  always #5 CLK = ~CLK;

  int checks = 0, errors = 0;
  int waits = 0, cnt = 0, tick = 0, ack_tick = -10, gap_err = 0;
  bit spur = 0;
  logic [11:0] mem [4096];
  int nrd = 0, nwr = 0;
  logic [11:0] rd_a = 0, wr_a = 0, wr_d = 0;
  int lat, last_ack;
  bit req_seen;

  // memory responder: ACK after `waits` wait cycles, optional stray ACKs while idle
  initial forever begin
    @(negedge CLK);
    tick++;
    if (MEM_REQ) begin
      if (ack_tick == tick - 1) gap_err++;
      if (cnt >= waits) begin
        MEM_ACK = 1;
        if (MEM_WE) begin
          mem[MEM_ADDR] = MEM_WDATA;
          nwr++;
          wr_a = MEM_ADDR;
          wr_d = MEM_WDATA;
        end else begin
          MEM_RDATA = mem[MEM_ADDR];
          nrd++;
          rd_a = MEM_ADDR;
        end
        ack_tick = tick;
        cnt = 0;
      end else begin
        MEM_ACK = 0;
        MEM_RDATA = 12'($urandom);
        cnt++;
      end
    end else begin
      MEM_ACK = spur ? 1'($urandom % 2) : 1'b0;
      MEM_RDATA = 12'($urandom);
      cnt = 0;
    end
  end

  task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %o expected %o", nm, act, exp);
    end
  endtask

  task automatic run(input logic [11:0] ir, input logic [11:0] pc, input int w);
    waits = w; nrd = 0; nwr = 0; gap_err = 0; lat = 0; last_ack = 0; req_seen = 0;
    @(negedge CLK); #1;
    IR = ir; PC = pc; START = 1;
    for (int n = 1; n <= 300 && lat == 0; n++) begin
      @(negedge CLK); #1;
      if (n == 1) begin
        START = 0;
        IR = 12'($urandom);
        PC = 12'($urandom);
      end
      if (DONE) lat = n;
      else begin
        if (MEM_REQ) req_seen = 1;
        if (MEM_REQ && MEM_ACK) last_ack = n;
      end
    end
    if (lat == 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: no DONE within 300 cycles for IR=%o PC=%o", ir, pc);
    end else begin
      @(negedge CLK); #1;
      check("done_single_pulse", 12'({DONE, BUSY}), 12'o0);
    end
  endtask

  // reference: addressing rules written as plain arithmetic on the memory image
  task automatic model(input logic [11:0] ir, input logic [11:0] pc, output logic [11:0] ea, output int rd, output int wr);
    int i, p, da, v;
    i = int'(ir); p = int'(pc);
    da = ir[7] ? (p / 128) * 128 + i % 128 : i % 128;
    rd = 0; wr = 0;
    if (!ir[8]) ea = 12'(da);
    else begin
      v = int'(mem[da]);
      rd = 1;
      if (EN && da >= 8 && da < 16) begin
        ea = 12'((v + 1) % 4096);
        wr = 1;
      end else ea = 12'(v);
    end
  endtask

  typedef struct {
    logic [11:0] ir, pc, mval;
    int w;
    logic [11:0] ea_en, ea_dis;
    bit wr_en;
    logic [11:0] ra;
  } vec_t;
  vec_t tbl[12];

  initial begin
    logic [11:0] e, r_ir, r_pc;
    int rd, wr, dones;
    tbl[0]  = '{12'o1205, 12'o4321, 12'o0000, 0, 12'o4205, 12'o4205, 1'b0, 12'o0000};
    tbl[1]  = '{12'o1405, 12'o4321, 12'o6000, 3, 12'o6000, 12'o6000, 1'b0, 12'o0005};
    tbl[2]  = '{12'o1412, 12'o4321, 12'o7777, 1, 12'o0000, 12'o7777, 1'b1, 12'o0012};
    tbl[3]  = '{12'o0205, 12'o0123, 12'o0000, 0, 12'o0005, 12'o0005, 1'b0, 12'o0000};
    tbl[4]  = '{12'o0005, 12'o0123, 12'o0000, 0, 12'o0005, 12'o0005, 1'b0, 12'o0000};
    tbl[5]  = '{12'o0377, 12'o7777, 12'o0000, 0, 12'o7777, 12'o7777, 1'b0, 12'o0000};
    tbl[6]  = '{12'o1600, 12'o2345, 12'o1234, 2, 12'o1234, 12'o1234, 1'b0, 12'o2200};
    tbl[7]  = '{12'o1407, 12'o0000, 12'o0100, 0, 12'o0100, 12'o0100, 1'b0, 12'o0007};
    tbl[8]  = '{12'o1410, 12'o0000, 12'o0100, 0, 12'o0101, 12'o0100, 1'b1, 12'o0010};
    tbl[9]  = '{12'o1417, 12'o0000, 12'o0003, 2, 12'o0004, 12'o0003, 1'b1, 12'o0017};
    tbl[10] = '{12'o1420, 12'o0000, 12'o0555, 0, 12'o0555, 12'o0555, 1'b0, 12'o0020};
    tbl[11] = '{12'o1610, 12'o0100, 12'o4444, 1, 12'o4445, 12'o4444, 1'b1, 12'o0010};
    for (int i = 0; i < 4096; i++) mem[i] = 12'($urandom);

    #2;
    check("rst_req", 12'(MEM_REQ), 12'o0);
    check("rst_we", 12'(MEM_WE), 12'o0);
    check("rst_addr", MEM_ADDR, 12'o0);
    check("rst_wdata", MEM_WDATA, 12'o0);
    check("rst_ea", EA, 12'o0);
    check("rst_busy_done", 12'({BUSY, DONE}), 12'o0);
    repeat (2) @(negedge CLK);
    CLR_N = 1;

    foreach (tbl[i]) begin
      if (tbl[i].ir[8]) mem[tbl[i].ra] = tbl[i].mval;
      run(tbl[i].ir, tbl[i].pc, tbl[i].w);
      e = EN ? tbl[i].ea_en : tbl[i].ea_dis;
      check("ea", EA, e);
      check("latency", 12'(lat), tbl[i].ir[8] ? 12'(last_ack + 1) : 12'd1);
      check("reads", 12'(nrd), 12'(tbl[i].ir[8]));
      check("writes", 12'(nwr), 12'(EN && tbl[i].wr_en));
      check("req_seen", 12'(req_seen), 12'(tbl[i].ir[8]));
      check("req_gap", 12'(gap_err), 12'd0);
      if (tbl[i].ir[8]) check("rd_addr", rd_a, tbl[i].ra);
      if (EN && tbl[i].wr_en) begin
        check("wr_addr", wr_a, tbl[i].ra);
        check("wr_data", wr_d, e);
      end
    end

    // START during IND_RD with a different IR is ignored
    waits = 4; nrd = 0; nwr = 0; dones = 0;
    mem[12'o0005] = 12'o6000;
    @(negedge CLK); #1;
    IR = 12'o1405; PC = 12'o0000; START = 1;
    @(negedge CLK); #1;
    START = 0;
    if (DONE) dones++;
    @(negedge CLK); #1;
    IR = 12'o0123; PC = 12'o7777; START = 1;
    @(negedge CLK); #1;
    START = 0;
    if (DONE) dones++;
    repeat (20) begin
      @(negedge CLK); #1;
      if (DONE) dones++;
    end
    check("busy_start_dones", 12'(dones), 12'd1);
    check("busy_start_ea", EA, 12'o6000);
    check("busy_start_reads", 12'(nrd), 12'd1);

    // START held into FIN is ignored
    @(negedge CLK); #1;
    IR = 12'o1205; PC = 12'o4321; START = 1;
    @(negedge CLK); #1;
    check("fin_done", 12'(DONE), 12'd1);
    IR = 12'o0007;
    @(negedge CLK); #1;
    START = 0;
    check("fin_start_idle", 12'({BUSY, DONE}), 12'o0);
    check("fin_start_ea", EA, 12'o4205);

    // async reset while a request is outstanding
    waits = 1000;
    @(negedge CLK); #1;
    IR = 12'o1405; PC = 12'o0000; START = 1;
    @(negedge CLK); #1;
    START = 0;
    @(negedge CLK); #1;
    check("req_before_rst", 12'(MEM_REQ), 12'd1);
    CLR_N = 0;
    #1;
    check("rst_mid_req", 12'(MEM_REQ), 12'o0);
    check("rst_mid_busy", 12'(BUSY), 12'o0);
    check("rst_mid_ea", EA, 12'o0);
    @(negedge CLK);
    CLR_N = 1;
    run(12'o1205, 12'o4321, 0);
    check("post_rst_ea", EA, 12'o4205);
    check("post_rst_lat", 12'(lat), 12'd1);

    // random instructions, stray ACKs while the port is idle
    spur = 1;
    repeat (200) begin
      r_ir = 12'($urandom);
      r_pc = 12'($urandom);
      if ($urandom % 4 == 0) r_ir[8:0] = {2'b10, 4'b0001, 3'($urandom)};
      model(r_ir, r_pc, e, rd, wr);
      run(r_ir, r_pc, int'($urandom_range(0, 3)));
      check("rnd_ea", EA, e);
      check("rnd_writes", 12'(nwr), 12'(wr));
      check("rnd_latency", 12'(lat), rd != 0 ? 12'(last_ack + 1) : 12'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
